gate_arbiter_ctl: RTL and testbench

- Frame-rate controller for the shared gate obstacle at x = GATE_X_MIN..GATE_X_MAX, which both players must pass.
- Arbitrates gate ownership between player 1 (mouse side) and player 2 (GPIO side) using round-robin priority.
- Sequences the gate through open/close travel and holds it open while the owner needs it.
- Never closes the gate on a player. Sits beside the player movement controller and feeds the gate renderer and the collision logic.

---
 rtl/gate_arbiter_ctl.sv | 146 ++++++++++++++
 tb/tb_gate_arbiter_ctl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_arbiter_ctl.sv
// Gate arbiter and open/close sequencer for the shared gate obstacle.
// Grants the gate to one player at a time (round-robin on ties), steps the
// gate level once per frame tick, and never closes while a player is inside.
module gate_arbiter_ctl #(
  parameter int unsigned TRAVEL_FRAMES = 8,
  parameter int unsigned HOLD_FRAMES   = 120,
  parameter int unsigned GATE_X_MIN    = 310,
  parameter int unsigned GATE_X_MAX    = 450
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        v_tick,
  input  logic        req1,
  input  logic        req2,
  input  logic [11:0] xpos_player1,
  input  logic [11:0] xpos_player2,
  output logic        grant1,
  output logic        grant2,
  output logic [7:0]  gate_level,
  output logic        gate_open,
  output logic        busy
);

  localparam logic [7:0]  TRAVEL = TRAVEL_FRAMES[7:0];
  localparam logic [11:0] HOLD   = HOLD_FRAMES[11:0];
  localparam logic [11:0] XMIN   = GATE_X_MIN[11:0];
  localparam logic [11:0] XMAX   = GATE_X_MAX[11:0];

  typedef enum logic [1:0] {
    CLOSED,
    OPENING,
    OPEN,
    CLOSING
  } state_t;

  state_t      state_q, state_d;
  logic        grant1_d, grant2_d;
  logic [7:0]  level_d;
  logic        open_d, busy_d;
  logic [11:0] hold_q, hold_d;
  logic        v_tick_old;
  logic        last_owner_q, last_owner_d;  // 1 = player 2 was the last owner

  logic        tick;
  logic        inside1, inside2, any_inside;
  logic        owner_req;
  logic [7:0]  level_inc, level_dec;
  logic [11:0] hold_inc;

  assign tick       = v_tick & ~v_tick_old;
  assign inside1    = (xpos_player1 >= XMIN) && (xpos_player1 <= XMAX);
  assign inside2    = (xpos_player2 >= XMIN) && (xpos_player2 <= XMAX);
  assign any_inside = inside1 | inside2;
  assign owner_req  = grant1 ? req1 : req2;

  // Clamped arithmetic: a reversal straight out of a fully-open CLOSING
  // re-enters OPENING at TRAVEL, so the increment must not overshoot.
  assign level_inc  = (gate_level >= TRAVEL) ? TRAVEL : gate_level + 8'd1;
  assign level_dec  = (gate_level == '0) ? '0 : gate_level - 8'd1;
  assign hold_inc   = (hold_q >= HOLD) ? HOLD : hold_q + 12'd1;

  // State, registered outputs and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLOSED;
      grant1       <= 1'b0;
      grant2       <= 1'b0;
      gate_level   <= '0;
      gate_open    <= 1'b0;
      busy         <= 1'b0;
      hold_q       <= '0;
      v_tick_old   <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant1       <= grant1_d;
      grant2       <= grant2_d;
      gate_level   <= level_d;
      gate_open    <= open_d;
      busy         <= busy_d;
      hold_q       <= hold_d;
      v_tick_old   <= v_tick;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state and next-output logic; everything holds between ticks.
  always_comb begin
    state_d      = state_q;
    grant1_d     = grant1;
    grant2_d     = grant2;
    level_d      = gate_level;
    open_d       = gate_open;
    busy_d       = busy;
    hold_d       = hold_q;
    last_owner_d = last_owner_q;

    if (tick) begin
      unique case (state_q)
        CLOSED: begin
          if (req1 && (!req2 || last_owner_q)) begin
            grant1_d     = 1'b1;
            last_owner_d = 1'b0;
            state_d      = OPENING;
            busy_d       = 1'b1;
          end else if (req2) begin
            grant2_d     = 1'b1;
            last_owner_d = 1'b1;
            state_d      = OPENING;
            busy_d       = 1'b1;
          end
        end
        OPENING: begin
          level_d = level_inc;
          if (level_inc == TRAVEL) begin
            state_d = OPEN;
            open_d  = 1'b1;
            hold_d  = '0;
          end
        end
        OPEN: begin
          hold_d = hold_inc;
          if (!any_inside && (!owner_req || (hold_inc >= HOLD))) begin
            state_d = CLOSING;
            open_d  = 1'b0;
          end
        end
        CLOSING: begin
          if (any_inside || owner_req) begin
            state_d = OPENING;
          end else begin
            level_d = level_dec;
            if (level_dec == '0) begin
              state_d  = CLOSED;
              grant1_d = 1'b0;
              grant2_d = 1'b0;
              busy_d   = 1'b0;
            end
          end
        end
        default: state_d = CLOSED;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_arbiter_ctl.sv
// Self-checking bench for gate_arbiter_ctl: directed scenarios followed by
// randomized ticks, all compared against a frame-level behavioural model.
module tb_gate_arbiter_ctl;

  localparam int unsigned TF = 4;
  localparam int unsigned HF = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_tick;
  logic        req1, req2;
  logic [11:0] xpos_player1, xpos_player2;
  logic        grant1, grant2;
  logic [7:0]  gate_level;
  logic        gate_open;
  logic        busy;

  int checks = 0;
  int errors = 0;

  gate_arbiter_ctl #(
    .TRAVEL_FRAMES(TF),
    .HOLD_FRAMES  (HF),
    .GATE_X_MIN   (310),
    .GATE_X_MAX   (450)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .v_tick       (v_tick),
    .req1         (req1),
    .req2         (req2),
    .xpos_player1 (xpos_player1),
    .xpos_player2 (xpos_player2),
    .grant1       (grant1),
    .grant2       (grant2),
    .gate_level   (gate_level),
    .gate_open    (gate_open),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Frame-level model: who owns the gate, how far open it is, and which way
  // it is moving.
  typedef enum int {P_IDLE, P_RISE, P_HELD, P_FALL} phase_t;
  int     m_owner;
  int     m_last;
  int     m_level;
  int     m_hold;
  phase_t m_phase;

  function automatic bit in_gate(input logic [11:0] x);
    return (x >= 12'd310) && (x <= 12'd450);
  endfunction

  task automatic model_reset();
    m_owner = 0;
    m_last  = 2;
    m_level = 0;
    m_hold  = 0;
    m_phase = P_IDLE;
  endtask

  task automatic model_tick();
    bit any_in;
    bit oreq;
    any_in = in_gate(xpos_player1) || in_gate(xpos_player2);
    oreq   = (m_owner == 1) ? req1 : req2;
    case (m_phase)
      P_IDLE: begin
        if (req1 && req2) m_owner = (m_last == 1) ? 2 : 1;
        else if (req1)    m_owner = 1;
        else if (req2)    m_owner = 2;
        if (m_owner != 0) begin
          m_last  = m_owner;
          m_phase = P_RISE;
        end
      end
      P_RISE: begin
        if (m_level < int'(TF)) m_level++;
        if (m_level == int'(TF)) begin
          m_phase = P_HELD;
          m_hold  = 0;
        end
      end
      P_HELD: begin
        if (m_hold < int'(HF)) m_hold++;
        if (!any_in && (!oreq || m_hold >= int'(HF))) m_phase = P_FALL;
      end
      default: begin
        if (any_in || oreq) begin
          m_phase = P_RISE;
        end else begin
          m_level--;
          if (m_level == 0) begin
            m_owner = 0;
            m_phase = P_IDLE;
          end
        end
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_grant1"},  32'(grant1),     32'(m_owner == 1));
    check({tag, "_grant2"},  32'(grant2),     32'(m_owner == 2));
    check({tag, "_level"},   32'(gate_level), 32'(m_level));
    check({tag, "_open"},    32'(gate_open),  32'(m_phase == P_HELD));
    check({tag, "_busy"},    32'(busy),       32'(m_owner != 0));
  endtask

  // One frame strobe: rise at a falling edge, sample after the capturing
  // rising edge, then drop.
  task automatic do_tick(input string tag);
    @(negedge clk);
    v_tick = 1'b1;
    model_tick();
    @(negedge clk);
    v_tick = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    v_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all("reset");
  endtask

  initial begin
    logic [11:0] pool [8];
    rst = 1'b1; v_tick = 1'b0; req1 = 1'b0; req2 = 1'b0;
    xpos_player1 = 12'd100; xpos_player2 = 12'd100;
    model_reset();
    pool[0] = 12'd100; pool[1] = 12'd309; pool[2] = 12'd310; pool[3] = 12'd380;
    pool[4] = 12'd450; pool[5] = 12'd451; pool[6] = 12'd0;   pool[7] = 12'd4095;

    // Basic open / close with player 1
    do_reset();
    check("rst_level", 32'(gate_level), 32'd0);
    req1 = 1'b1;
    do_tick("open1");
    check("open1_grant1", 32'(grant1), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      do_tick("opening");
      check("opening_level", 32'(gate_level), 32'(i - 1));
    end
    check("open1_gate_open", 32'(gate_open), 32'd1);
    req1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      do_tick("closing");
      check("closing_level", 32'(gate_level), 32'(5 - k));
    end
    check("closed_grant1", 32'(grant1), 32'd0);

    // Round-robin ties
    do_reset();
    req1 = 1'b1; req2 = 1'b1;
    do_tick("tie1");
    check("tie1_grant1", 32'(grant1), 32'd1);
    req1 = 1'b0;
    for (int n = 0; n < 40 && m_owner != 0; n++) do_tick("drain1");
    check("drain1_busy", 32'(busy), 32'd0);
    req1 = 1'b1;
    do_tick("tie2");
    check("tie2_grant2", 32'(grant2), 32'd1);
    req2 = 1'b0;
    for (int n = 0; n < 40 && m_owner != 0; n++) do_tick("drain2");
    req2 = 1'b1;
    do_tick("tie3");
    check("tie3_grant1", 32'(grant1), 32'd1);

    // Occupancy holds the gate past timeout; boundary reversal in CLOSING
    do_reset();
    req1 = 1'b1; req2 = 1'b0; xpos_player1 = 12'd380;
    for (int i = 0; i < 5; i++) do_tick("occ_open");
    for (int i = 0; i < 12; i++) do_tick("occ_hold");
    check("occ_still_open", 32'(gate_open), 32'd1);
    xpos_player1 = 12'd460; req1 = 1'b0;
    do_tick("occ_leave");
    check("occ_leave_open", 32'(gate_open), 32'd0);
    do_tick("occ_dec3");
    do_tick("occ_dec2");
    check("occ_level2", 32'(gate_level), 32'd2);
    xpos_player2 = 12'd310;
    do_tick("rev");
    check("rev_level_held", 32'(gate_level), 32'd2);
    do_tick("rev_up");
    check("rev_level3", 32'(gate_level), 32'd3);
    xpos_player1 = 12'd100; xpos_player2 = 12'd100;

    // Long v_tick level gives a single advance; reset while fully open
    do_reset();
    req1 = 1'b1;
    @(negedge clk);
    v_tick = 1'b1;
    model_tick();
    repeat (20) @(negedge clk);
    v_tick = 1'b0;
    check_all("long_tick");
    check("long_tick_level", 32'(gate_level), 32'd0);
    for (int i = 0; i < 4; i++) do_tick("to_open");
    check("to_open_level", 32'(gate_level), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("midrst_outputs", {27'd0, grant1, grant2, gate_open, busy, |gate_level}, 32'd0);
    check_all("midrst");

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 99) < 30) req1 = ~req1;
      if ($urandom_range(0, 99) < 30) req2 = ~req2;
      if ($urandom_range(0, 99) < 25)
        xpos_player1 = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 7)] : 12'($urandom());
      if ($urandom_range(0, 99) < 25)
        xpos_player2 = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 7)] : 12'($urandom());
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        do_tick("rand");
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
          check_all("rand_idle");
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
